// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, request op enum and encoder FSM states.
// ENC_NOP_PAD_EN adds the PAD state used to fill the remaining words with NOPs.
package riscv_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;

   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [2:0] {
      OP_R    = 3'd0,
      OP_LW   = 3'd1,
      OP_SW   = 3'd2,
      OP_BEQ  = 3'd3,
      OP_IALU = 3'd4
   } req_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
`ifdef ENC_NOP_PAD_EN
      ST_FULL,
      ST_PAD
`else
      ST_FULL
`endif
   } enc_state_e;

   function automatic logic op_is_legal(input logic [2:0] op);
      return op <= OP_IALU;
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: request op plus register/immediate fields into one RV32I word.
// Illegal ops produce a zero word and raise illegal.
module instr_field_pack
   import riscv_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic        alt,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = !op_is_legal(op);
      case (op)
         OP_R:    word = {(alt ? F7_ALT : F7_BASE), rs2, rs1, funct3, rd, OPC_RTYPE};
         OP_LW:   word = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
         OP_SW:   word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
         // branch offset is halfword-scaled, so imm[0] never reaches the word
         OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
         OP_IALU: word = {imm[11:0], rs1, funct3, rd, OPC_IALU};
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/instr_stream_encoder.sv
// Session-based instruction writer: encodes requests and streams them into IMEM.
// Optional ENC_NOP_PAD_EN pads the rest of the session with NOPs after finish.
module instr_stream_encoder
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [2:0]        req_funct3,
   input  logic              req_alt,
   input  logic [12:0]       req_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              done,
   output logic              err_illegal
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

   enc_state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_inc;
   logic [31:0]       enc_word;
   logic              enc_illegal;
   logic              accept;
   logic              wr_req;
   logic              pad_wr;
   logic              sess_start;
   logic              sess_close;

   instr_field_pack u_pack (
      .op      (req_op),
      .rd      (req_rd),
      .rs1     (req_rs1),
      .rs2     (req_rs2),
      .funct3  (req_funct3),
      .alt     (req_alt),
      .imm     (req_imm),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   assign count_inc = count_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (finish) begin
`ifdef ENC_NOP_PAD_EN
               // a coincident write may itself complete the session, so skip PAD then
               if ((wr_req ? count_inc : count_q) >= DEPTH_C) state_d = ST_IDLE;
               else                                          state_d = ST_PAD;
`else
               state_d = ST_IDLE;
`endif
            end else if (wr_req && count_inc == DEPTH_C) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (finish) state_d = ST_IDLE;
         end
`ifdef ENC_NOP_PAD_EN
         ST_PAD: begin
            if (count_inc >= DEPTH_C) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == ST_ACTIVE);
      accept     = req_valid && req_ready;
      wr_req     = accept && !enc_illegal;
      sess_start = (state_q == ST_IDLE) && start;
      sess_close = (state_q != ST_IDLE) && (state_d == ST_IDLE);
`ifdef ENC_NOP_PAD_EN
      pad_wr     = (state_q == ST_PAD);
`else
      pad_wr     = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= BASE_C;
         count_q     <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         imem_we     <= wr_req || pad_wr;
         done        <= sess_close;
         err_illegal <= accept && enc_illegal;
         if (sess_start) begin
            addr_q  <= BASE_C;
            count_q <= '0;
         end else if (wr_req || pad_wr) begin
            imem_addr  <= addr_q;
            imem_wdata <= pad_wr ? NOP_WORD : enc_word;
            addr_q     <= addr_q + 1'b1;
            count_q    <= count_inc;
         end
      end
   end

   assign count = count_q;
   assign full  = (count_q == DEPTH_C);

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder with DEPTH=4; PAD sequence runs when ENC_NOP_PAD_EN is defined.
module tb_instr_stream_encoder;
   import riscv_pkg::*;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              finish;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [2:0]        req_funct3;
   logic              req_alt;
   logic [12:0]       req_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              done;
   logic              err_illegal;

   int unsigned errors = 0;
   int unsigned checks = 0;

   instr_stream_encoder #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .BASE_ADDR (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .finish      (finish),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_rd      (req_rd),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .req_funct3  (req_funct3),
      .req_alt     (req_alt),
      .req_imm     (req_imm),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .count       (count),
      .full        (full),
      .done        (done),
      .err_illegal (err_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [2:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic alt, input logic [12:0] imm);
      req_valid  = v;
      req_op     = op;
      req_rd     = rd;
      req_rs1    = rs1;
      req_rs2    = rs2;
      req_funct3 = f3;
      req_alt    = alt;
      req_imm    = imm;
   endtask

   task automatic check_write(input string tag, input logic [7:0] addr, input logic [31:0] word,
                              input logic [8:0] cnt);
      check({tag, "_we"},    32'(imem_we),    32'd1);
      check({tag, "_addr"},  32'(imem_addr),  32'(addr));
      check({tag, "_wdata"}, imem_wdata,      word);
      check({tag, "_count"}, 32'(count),      32'(cnt));
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      finish = 1'b0;
      set_req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
      #3;
      check("rst_we",    32'(imem_we),     32'd0);
      check("rst_addr",  32'(imem_addr),   32'd0);
      check("rst_wdata", imem_wdata,       32'd0);
      check("rst_count", 32'(count),       32'd0);
      check("rst_full",  32'(full),        32'd0);
      check("rst_done",  32'(done),        32'd0);
      check("rst_err",   32'(err_illegal), 32'd0);
      check("rst_ready", 32'(req_ready),   32'd0);

      step();
      rst_n = 1'b1;
      step();
      check("idle_ready", 32'(req_ready), 32'd0);

      start = 1'b1;
      step();
      start = 1'b0;
      check("act_ready", 32'(req_ready), 32'd1);
      check("act_count", 32'(count),     32'd0);
      check("act_we",    32'(imem_we),   32'd0);

      // back-to-back requests fill all four words
      set_req(1'b1, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd5);
      step();
      check_write("addi", 8'd0, 32'h0050_0093, 9'd1);
      set_req(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0);
      step();
      check_write("r_alt", 8'd1, 32'h4020_81B3, 9'd2);
      set_req(1'b1, 3'd1, 5'd5, 5'd2, 5'd0, 3'd7, 1'b0, 13'd8);
      step();
      check_write("lw", 8'd2, 32'h0081_2283, 9'd3);
      set_req(1'b1, 3'd2, 5'd0, 5'd2, 5'd5, 3'd7, 1'b0, 13'd12);
      step();
      check_write("sw", 8'd3, 32'h0051_2623, 9'd4);
      check("full_set",   32'(full),      32'd1);
      check("full_ready", 32'(req_ready), 32'd0);

      set_req(1'b1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8);
      step();
      check("stall_we",    32'(imem_we), 32'd0);
      check("stall_count", 32'(count),   32'd4);
      req_valid = 1'b0;
      finish = 1'b1;
      step();
      finish = 1'b0;
      check("fin_done",  32'(done),      32'd1);
      check("fin_full",  32'(full),      32'd1);
      check("fin_ready", 32'(req_ready), 32'd0);
      step();
      check("fin_done_clr", 32'(done), 32'd0);

      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_full",  32'(full),  32'd0);
      check("restart_count", 32'(count), 32'd0);

      set_req(1'b1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8);
      step();
      check_write("beq", 8'd0, 32'hFE20_8CE3, 9'd1);

      set_req(1'b1, 3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0);
      step();
      req_valid = 1'b0;
      check("ill_err",   32'(err_illegal), 32'd1);
      check("ill_we",    32'(imem_we),     32'd0);
      check("ill_count", 32'(count),       32'd1);
      step();
      check("ill_err_clr", 32'(err_illegal), 32'd0);

      // finish together with an accept: the word still lands at addr 1
      set_req(1'b1, 3'd4, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 13'h1FFF);
      finish = 1'b1;
      step();
      req_valid = 1'b0;
      finish = 1'b0;
      check_write("fin_acc", 8'd1, 32'hFFF0_8113, 9'd2);
      check("fin_acc_ready", 32'(req_ready), 32'd0);
`ifdef ENC_NOP_PAD_EN
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
         end
         check("fin_acc_pad_done", 32'(seen),  32'd1);
         check("fin_acc_pad_cnt",  32'(count), 32'd4);
      end
`else
      check("fin_acc_done", 32'(done), 32'd1);
`endif

      step();
      start = 1'b1;
      step();
      start = 1'b0;
      set_req(1'b1, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd5);
      step();
      req_valid = 1'b0;
      check_write("pre_rst", 8'd0, 32'h0050_0093, 9'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_we",    32'(imem_we),    32'd0);
      check("arst_addr",  32'(imem_addr),  32'd0);
      check("arst_wdata", imem_wdata,      32'd0);
      check("arst_count", 32'(count),      32'd0);
      check("arst_ready", 32'(req_ready),  32'd0);
      step();
      rst_n = 1'b1;

`ifdef ENC_NOP_PAD_EN
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      set_req(1'b1, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd5);
      step();
      req_valid = 1'b0;
      check_write("pad_first", 8'd0, 32'h0050_0093, 9'd1);
      finish = 1'b1;
      step();
      finish = 1'b0;
      check("pad_enter_we",    32'(imem_we),   32'd0);
      check("pad_enter_ready", 32'(req_ready), 32'd0);
      step();
      check_write("pad1", 8'd1, 32'h0000_0013, 9'd2);
      check("pad1_done", 32'(done), 32'd0);
      step();
      check_write("pad2", 8'd2, 32'h0000_0013, 9'd3);
      check("pad2_done", 32'(done), 32'd0);
      step();
      check_write("pad3", 8'd3, 32'h0000_0013, 9'd4);
      check("pad3_done", 32'(done), 32'd1);
      step();
      check("pad_end_we",   32'(imem_we), 32'd0);
      check("pad_end_done", 32'(done),    32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Encoder-side counterpart of the control decoder: takes symbolic instruction requests and encodes them into RV32I 32-bit words; opcodes match exactly those the decoder recognises.
- Writes encoded words sequentially into instruction memory through a simple write port.
- Used by the test harness and boot path to build programs in IMEM without external assembler images.
- Supported opcodes: R-type 0110011, LW 0000011, SW 0100011, BEQ 1100011, I-ALU 0010011.

Parameters:
- ADDR_W, 8, IMEM word-address width.
- DEPTH, 64, number of words the block may write per session; DEPTH ≤ 2^ADDR_W.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin session; honoured only in IDLE.
- finish  in  1  end session; honoured in ACTIVE or FULL.
- req_valid  in  1  instruction request valid.
- req_ready  out  1  block can accept a request.
- req_op  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI/I-ALU, 5–7 illegal.
- req_rd  in  5  destination register.
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2.
- req_funct3  in  3  funct3 for R and I-ALU; ignored for LW/SW (forced 010) and BEQ (forced 000).
- req_alt  in  1  R only: funct7 = 0100000 when 1, else 0000000.
- req_imm  in  13  signed immediate: bits[11:0] for LW/SW/I-ALU; bits[12:1] for BEQ (bit0 ignored).
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- full  out  1  count == DEPTH.
- done  out  1  one-cycle pulse when the session closes.
- err_illegal  out  1  one-cycle pulse when an illegal req_op is accepted.

Behaviour:
- Reset: all outputs 0; state IDLE; address = BASE_ADDR; count = 0.
- State IDLE: req_ready=0. start → ACTIVE; address ← BASE_ADDR; count ← 0.
- State ACTIVE: req_ready=1. A request is accepted when req_valid && req_ready.
- Latency: exactly one cycle. The cycle after acceptance, imem_we=1, imem_addr holds the current address, and imem_wdata holds the encoded word (all registered). In that same edge, address += 1 and count += 1.
- Address wraps modulo 2^ADDR_W.
- When count reaches DEPTH → FULL. FULL: req_ready=0, full=1.
- Illegal op: the request is accepted, no write occurs, count is unchanged, and err_illegal pulses on the following cycle.
- finish in ACTIVE/FULL → IDLE; done pulses on the following cycle. full clears on the next start.
- finish coincident with an accept: the word is still written; the transition happens after it.
- start outside IDLE: ignored. start and finish together in IDLE: start wins.
- Encodings:
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}.
  - LW: {imm[11:0], rs1, 010, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
  - ADDI: {imm[11:0], rs1, funct3, rd, 0010011}.
- rst_n low mid-session: immediate return to reset values; any pending write is dropped.

Optional Feature:
- Macro: ENC_NOP_PAD_EN.
- Defined: finish in ACTIVE enters state PAD instead of IDLE.
  - PAD writes NOP 0x00000013 once per cycle (req_ready=0) until count == DEPTH.
  - Then → IDLE with a done pulse. finish in FULL goes directly to IDLE.
- Undefined: no PAD state; finish → IDLE immediately.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_IALU (shared with the control decoder);
  - req_op enum;
  - NOP_WORD;
  - funct3 constants F3_LW, F3_SW, F3_BEQ.
- Sub-module instr_field_pack: purely combinational op+fields → 32-bit word. FSM, counters and write register live in the top.

Test Plan:
- start, then ADDI rd=1 rs1=0 f3=0 imm=5 → next cycle imem_we=1, addr=0, wdata=0x00500093, count=1.
- R alt=1 rd=3 rs1=1 rs2=2 f3=0 → 0x402081B3; LW rd=5 rs1=2 imm=8 → 0x00812283; SW rs2=5 rs1=2 imm=12 → 0x00512623 at consecutive addresses 1–3.
- BEQ rs1=1 rs2=2 imm=-8 (0x1FF8) → 0xFE208CE3.
- Back-to-back valid for DEPTH=4: 4 writes to addrs 0–3, full=1, req_ready=0; the 5th request stalls; finish → done pulse.
- req_op=6 accepted → err_illegal pulse, no imem_we, count unchanged; rst_n low mid-session → all outputs 0 asynchronously.
- With ENC_NOP_PAD_EN and DEPTH=4: 1 write, then finish → 3 cycles writing 0x00000013 at addrs 1–3, then done.
